// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX pin among NUM_REQ byte sources, with a built-in 8N1 serializer.
// Define UART_ARB_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_arbiter #(
  parameter int CLK_HZ  = 27000000,
  parameter int BAUD    = 115200,
  parameter int NUM_REQ = 2
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [1:0]           grant_id
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic [1:0]    LAST_RST  = 2'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_ARB_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic [1:0]      last_grant;
  logic            win_found;
  logic [1:0]      win_idx;
  logic [7:0]      win_byte;
  logic            accept;
  logic            bit_end;
  int              cand;
`ifdef UART_ARB_PARITY_EN
  logic            parity_bit;
`endif

  // Search starts just after the last winner and wraps, so every valid source is served in turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    win_byte  = 8'h00;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_found && (j == cand) && req_valid[j]) begin
          win_found = 1'b1;
          win_idx   = 2'(j);
          win_byte  = req_data[8*j +: 8];
        end
      end
    end
  end

  assign accept  = (state == ST_IDLE) && win_found;
  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge sys_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept)  next_state = ST_START;
      ST_START: if (bit_end) next_state = ST_DATA;
      ST_DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_ARB_PARITY_EN
          next_state = ST_PARITY;
`else
          next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_ARB_PARITY_EN
      ST_PARITY: if (bit_end) next_state = ST_STOP;
`endif
      ST_STOP:  if (bit_end) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Counters idle at zero so every frame starts with a full-length start bit.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      grant_id   <= 2'd0;
      last_grant <= LAST_RST;
`ifdef UART_ARB_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      if (accept) begin
        shift_reg  <= win_byte;
        grant_id   <= win_idx;
        last_grant <= win_idx;
`ifdef UART_ARB_PARITY_EN
        parity_bit <= ^win_byte;
`endif
      end
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if ((state == ST_DATA) && bit_end) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    busy      = (state != ST_IDLE);
    tx        = 1'b1;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = accept && (win_idx == 2'(j));
    end
    case (state)
      ST_IDLE:   tx = 1'b1;
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shift_reg[0];
`ifdef UART_ARB_PARITY_EN
      ST_PARITY: tx = parity_bit;
`endif
      ST_STOP:   tx = 1'b1;
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed steps plus a random phase, compared every cycle
// against a frame-level reference model (frame bit = cycle offset / CPB, round-robin by modulo search).
module tb_uart_tx_arbiter;

  localparam int CLK_HZ  = 1000000;
  localparam int BAUD    = 100000;
  localparam int NUM_REQ = 2;
  localparam int CPB     = CLK_HZ / BAUD;
`ifdef UART_ARB_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic                 sys_clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx;
  logic                 busy;
  logic [1:0]           grant_id;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_REQ(NUM_REQ)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  int          ready0_cnt = 0;
  logic        drv_reset = 1'b1;
  bit          one_shot = 1'b1;
  bit          src_valid [NUM_REQ];
  logic [7:0]  src_data [NUM_REQ];
  bit          mdl_active = 1'b0;
  bit          mdl_accepted = 1'b0;
  int          mdl_off = 0;
  logic [7:0]  mdl_byte = 8'h00;
  int          mdl_grant = 0;
  int          mdl_last = NUM_REQ - 1;
  int          acc_cyc[$];
  int          acc_id[$];

  // Line value for bit slot idx of a frame carrying byte b.
  function automatic logic frame_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_ARB_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic int mdl_winner();
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (mdl_last + k) % NUM_REQ;
      if (src_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    reset = drv_reset;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]        = src_valid[i];
      req_data[8*i +: 8]  = src_data[i];
    end
  endtask

  task automatic checkOutput();
    int                 w;
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_tx;
    w         = mdl_winner();
    exp_ready = '0;
    if (!mdl_active && w >= 0) exp_ready[w] = 1'b1;
    exp_tx = mdl_active ? frame_bit(mdl_byte, mdl_off / CPB) : 1'b1;
    compare("tx", 32'(tx), 32'(exp_tx));
    compare("busy", 32'(busy), 32'(mdl_active));
    compare("grant_id", 32'(grant_id), 32'(mdl_grant));
    compare("req_ready", 32'(req_ready), 32'(exp_ready));
    if (req_ready[0]) ready0_cnt++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        acc_cyc.push_back(cycle);
        acc_id.push_back(i);
      end
    end
  endtask

  task automatic model_step();
    int w;
    w = mdl_winner();
    mdl_accepted = 1'b0;
    if (drv_reset) begin
      mdl_active = 1'b0;
      mdl_off    = 0;
      mdl_grant  = 0;
      mdl_last   = NUM_REQ - 1;
    end else if (mdl_active) begin
      mdl_off++;
      if (mdl_off == FRAME) mdl_active = 1'b0;
    end else if (w >= 0) begin
      mdl_active   = 1'b1;
      mdl_off      = 0;
      mdl_byte     = src_data[w];
      mdl_grant    = w;
      mdl_last     = w;
      mdl_accepted = 1'b1;
      if (one_shot) src_valid[w] = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    applyStimulus();
    #1;
    checkOutput();
    model_step();
    cycle++;
  endtask

  task automatic wait_accept(input int bound);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!mdl_accepted && n < bound);
    compare("accept_within_bound", 32'(busy || mdl_accepted), 32'(1));
  endtask

  task automatic reset_pulse();
    drv_reset = 1'b1;
    tick();
    drv_reset = 1'b0;
    acc_cyc.delete();
    acc_id.delete();
  endtask

  task automatic randomize_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!src_valid[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          src_valid[i] = 1'b1;
          src_data[i]  = 8'($urandom);
        end
      end else if ($urandom_range(0, 149) == 0) begin
        src_valid[i] = 1'b0;
      end
    end
    drv_reset = ($urandom_range(0, 399) == 0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src_valid[i] = 1'b0;
      src_data[i]  = 8'h00;
    end

    $display("[TB] step 1: reset, idle line");
    repeat (3) tick();
    drv_reset = 1'b0;
    repeat (50) tick();

    $display("[TB] step 2: requester 0 sends 0xA5");
    ready0_cnt   = 0;
    src_data[0]  = 8'hA5;
    src_valid[0] = 1'b1;
    repeat (FRAME + 10) tick();
    compare("ready0_one_cycle", 32'(ready0_cnt), 32'(1));

    $display("[TB] step 3: both requesters continuously valid");
    reset_pulse();
    one_shot     = 1'b0;
    src_data[0]  = 8'h11;
    src_data[1]  = 8'h22;
    src_valid[0] = 1'b1;
    src_valid[1] = 1'b1;
    repeat (4 * (FRAME + 1)) tick();
    src_valid[0] = 1'b0;
    src_valid[1] = 1'b0;
    one_shot     = 1'b1;
    repeat (FRAME + 2) tick();
    compare("rr_accept_count", 32'(acc_id.size()), 32'(4));
    for (int k = 0; k < acc_id.size(); k++) begin
      compare("rr_grant_order", 32'(acc_id[k]), 32'(k % 2));
      if (k > 0) compare("rr_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(FRAME + 1));
    end

    $display("[TB] step 4: requester 0 arrives mid-frame");
    reset_pulse();
    src_data[1]  = 8'h3C;
    src_valid[1] = 1'b1;
    repeat (50) tick();
    compare("grant_mid_frame", 32'(grant_id), 32'(1));
    src_data[0]  = 8'($urandom);
    src_valid[0] = 1'b1;
    repeat (FRAME + 60) tick();
    compare("late_accept_count", 32'(acc_id.size()), 32'(2));
    if (acc_id.size() == 2) begin
      compare("late_first_id", 32'(acc_id[0]), 32'(1));
      compare("late_second_id", 32'(acc_id[1]), 32'(0));
      compare("late_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(FRAME + 1));
    end
    compare("grant_after", 32'(grant_id), 32'(0));

    $display("[TB] step 5: reset mid-frame");
    reset_pulse();
    src_data[0]  = 8'hFF;
    src_valid[0] = 1'b1;
    wait_accept(5);
    repeat (45) tick();
    drv_reset    = 1'b1;
    src_data[0]  = 8'($urandom);
    src_valid[0] = 1'b1;
    tick();
    drv_reset = 1'b0;
    tick();
    compare("ready_after_reset", 32'(req_ready), 32'(2'b01));
    compare("tx_after_reset", 32'(tx), 32'(1));
    compare("busy_after_reset", 32'(busy), 32'(0));
    repeat (FRAME + 5) tick();

`ifdef UART_ARB_PARITY_EN
    $display("[TB] step 6: parity frame for 0x07");
    reset_pulse();
    src_data[0]  = 8'h07;
    src_valid[0] = 1'b1;
    wait_accept(5);
    repeat (9 * CPB + 6) tick();
    compare("parity_bit", 32'(tx), 32'(1));
    repeat (FRAME - (9 * CPB + 6) + 1) tick();
    compare("parity_frame_end", 32'(busy), 32'(0));
`endif

    $display("[TB] random phase");
    for (int n = 0; n < 3000; n++) begin
      randomize_sources();
      tick();
    end
    drv_reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_valid[i] = 1'b0;
    repeat (FRAME + 5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
